// File: rtl/toy_dmem_responder.sv
// toy_dmem_responder: word-addressed data memory answering the RISC_TOY core's
// DREQ/DRW/DADDR/DWDATA/DRDATA port. It accepts one request per cycle, returns
// read data after a fixed latency of LAT cycles, flags out-of-range accesses
// and keeps saturating read/write counters.
//
// Ports:
//   CLK      clock; all state changes on the rising edge
//   RST      synchronous active-high reset
//   DREQ     request valid, sampled every cycle (no back-pressure)
//   DRW      1 = write, 0 = read
//   DADDR    30-bit word address
//   DWDATA   write data
//   DRDATA   read data; holds the last returned value
//   RVALID   one-cycle pulse marking a new DRDATA value
//   RD_CNT   accepted reads (saturating, includes out-of-range reads)
//   WR_CNT   accepted in-range writes (saturating)
//   ERR      sticky out-of-range flag
//   ERR_ADDR DADDR of the first out-of-range access
module toy_dmem_responder #(
  parameter int unsigned AW   = 10,
  parameter logic [29:0] BASE = 30'h0,
  parameter int unsigned LAT  = 1,
  parameter int unsigned CW   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [29:0]   DADDR,
  input  logic [31:0]   DWDATA,
  output logic [31:0]   DRDATA,
  output logic          RVALID,
  output logic [CW-1:0] RD_CNT,
  output logic [CW-1:0] WR_CNT,
  output logic          ERR,
  output logic [29:0]   ERR_ADDR
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];

  logic          in_range_c;
  logic [AW-1:0] idx_c;
  logic          rd_acc_c;
  logic          wr_acc_c;
  logic          oor_c;
  logic [31:0]   rd_word_c;
  logic          out_v_c;
  logic [31:0]   out_d_c;

  // Request decode; out-of-range reads return zero.
  always_comb begin
    in_range_c = (DADDR[29:AW] == BASE[29:AW]);
    idx_c      = DADDR[AW-1:0];
    rd_acc_c   = DREQ && !DRW;
    wr_acc_c   = DREQ && DRW && in_range_c;
    oor_c      = DREQ && !in_range_c;
    rd_word_c  = in_range_c ? mem[idx_c] : 32'h0;
  end

  // Array write; a request presented during reset is ignored.
  always_ff @(posedge CLK) begin
    if (!RST && wr_acc_c) begin
      mem[idx_c] <= DWDATA;
    end
  end

  // Counters and error capture update at the accepting edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_CNT   <= '0;
      WR_CNT   <= '0;
      ERR      <= 1'b0;
      ERR_ADDR <= 30'h0;
    end else begin
      if (rd_acc_c && (RD_CNT != '1)) begin
        RD_CNT <= RD_CNT + CW'(1);
      end
      if (wr_acc_c && (WR_CNT != '1)) begin
        WR_CNT <= WR_CNT + CW'(1);
      end
      if (oor_c && !ERR) begin
        ERR      <= 1'b1;
        ERR_ADDR <= DADDR;
      end
    end
  end

  // The output register is the last latency stage, so LAT-1 stages sit in front of it.
  if (LAT == 1) begin : g_direct
    assign out_v_c = rd_acc_c;
    assign out_d_c = rd_word_c;
  end else begin : g_pipe
    localparam int unsigned PD = LAT - 1;

    logic [PD-1:0] pipe_v;
    logic [31:0]   pipe_d [PD];

    // Valid bits are reset so in-flight reads are discarded.
    always_ff @(posedge CLK) begin
      if (RST) begin
        pipe_v <= '0;
      end else begin
        pipe_v[0] <= rd_acc_c;
        for (int i = 1; i < int'(PD); i++) begin
          pipe_v[i] <= pipe_v[i-1];
        end
      end
    end

    // Data travels alongside the valid bits and needs no reset.
    always_ff @(posedge CLK) begin
      pipe_d[0] <= rd_word_c;
      for (int i = 1; i < int'(PD); i++) begin
        pipe_d[i] <= pipe_d[i-1];
      end
    end

    assign out_v_c = pipe_v[PD-1];
    assign out_d_c = pipe_d[PD-1];
  end

  // Response register; DRDATA only moves on a valid slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RVALID <= 1'b0;
      DRDATA <= 32'h0;
    end else begin
      RVALID <= out_v_c;
      if (out_v_c) begin
        DRDATA <= out_d_c;
      end
    end
  end

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Bench for toy_dmem_responder (LAT=3, CW=5, AW=10, BASE=0). A reference model
// observes the requests the bench issues at each rising edge and queues the
// expected responses; a monitor on the falling edge pops and compares them,
// and also checks DRDATA hold, counters, ERR and ERR_ADDR every cycle.
module tb_toy_dmem_responder;

  localparam int unsigned AW    = 10;
  localparam logic [29:0] BASE  = 30'h0;
  localparam int unsigned LAT   = 3;
  localparam int unsigned CW    = 5;
  localparam int unsigned MAXC  = (1 << CW) - 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          DREQ = 1'b0;
  logic          DRW = 1'b0;
  logic [29:0]   DADDR = 30'h0;
  logic [31:0]   DWDATA = 32'h0;
  logic [31:0]   DRDATA;
  logic          RVALID;
  logic [CW-1:0] RD_CNT;
  logic [CW-1:0] WR_CNT;
  logic          ERR;
  logic [29:0]   ERR_ADDR;

  toy_dmem_responder #(.AW(AW), .BASE(BASE), .LAT(LAT), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR),
    .DWDATA(DWDATA), .DRDATA(DRDATA), .RVALID(RVALID), .RD_CNT(RD_CNT),
    .WR_CNT(WR_CNT), .ERR(ERR), .ERR_ADDR(ERR_ADDR)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [31:0] mm [int];
  int unsigned e = 0;
  int unsigned rst_edge = 32'hFFFF_FFFF;
  bit          armed = 0;
  int unsigned m_rd = 0;
  int unsigned m_wr = 0;
  bit          m_err = 0;
  logic [29:0] m_err_addr = 30'h0;
  logic [31:0] q_data [256];
  int unsigned q_due [256];
  logic [7:0]  wp = 8'd0;
  logic [7:0]  rp = 8'd0;

  // Monitor state
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q = 32'h0;
  bit          fin_req = 0;
  bit          fin_done = 0;

  // Model: applies the rules to whatever request is sampled at each edge.
  always @(posedge CLK) begin
    bit inr;
    int k;
    e = e + 1;
    if (RST) begin
      armed = 1;
      m_rd = 0;
      m_wr = 0;
      m_err = 0;
      m_err_addr = 30'h0;
      rst_edge = e;
    end else if (armed && DREQ) begin
      inr = ((DADDR >> AW) == (BASE >> AW));
      k = int'(DADDR - BASE);
      if (!inr && !m_err) begin
        m_err = 1;
        m_err_addr = DADDR;
      end
      if (DRW) begin
        if (inr) begin
          mm[k] = DWDATA;
          if (m_wr < MAXC) m_wr = m_wr + 1;
        end
      end else begin
        if (m_rd < MAXC) m_rd = m_rd + 1;
        q_data[wp] = (inr && mm.exists(k)) ? mm[k] : 32'h0;
        q_due[wp]  = e + LAT - 1;
        wp = wp + 8'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, e, act, expv);
    end
  endtask

  // Monitor: pops expected responses as the DUT presents them.
  always @(negedge CLK) begin
    bit exp_v;
    if (armed) begin
      if (rst_edge == e) begin
        rp = wp;
        exp_q = 32'h0;
      end
      exp_v = (rp != wp) && (q_due[rp] == e);
      chk("rvalid", 32'(RVALID), 32'(exp_v));
      if (exp_v) begin
        chk("rdata", DRDATA, q_data[rp]);
        exp_q = q_data[rp];
        rp = rp + 8'd1;
      end
      while ((rp != wp) && (q_due[rp] < e)) rp = rp + 8'd1;
      chk("drdata_hold", DRDATA, exp_q);
      chk("rd_cnt", 32'(RD_CNT), m_rd);
      chk("wr_cnt", 32'(WR_CNT), m_wr);
      chk("err", 32'(ERR), 32'(m_err));
      chk("err_addr", 32'(ERR_ADDR), 32'(m_err_addr));
      if (fin_req && !fin_done) begin
        chk("drain", 32'(rp), 32'(wp));
        fin_done = 1;
      end
    end
  end

  // One bus cycle: the values driven here are sampled at the next rising edge.
  task automatic cyc(input logic r, input logic v, input logic rw,
                     input logic [29:0] a, input logic [31:0] d);
    @(posedge CLK);
    #1;
    RST    = r;
    DREQ   = v;
    DRW    = rw;
    DADDR  = a;
    DWDATA = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
  endtask

  initial begin
    logic [29:0] a;
    int r;

    // reset
    cyc(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);

    // write then immediate readback
    cyc(1'b0, 1'b1, 1'b1, 30'd5, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b1, 1'b0, 30'd5, 32'h0);

    // preload and back-to-back reads
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 30'(i), 32'h10 + 32'(i));
    cyc(1'b0, 1'b1, 1'b1, 30'd7, 32'h77);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 30'(i), 32'h0);

    // single read then bubbles
    cyc(1'b0, 1'b1, 1'b0, 30'd7, 32'h0);
    idle(5);

    // write presented during reset must be ignored
    cyc(1'b1, 1'b1, 1'b1, 30'd5, 32'h1234_5678);
    cyc(1'b0, 1'b1, 1'b0, 30'd5, 32'h0);
    idle(LAT + 1);

    // out-of-range write and read, then check index 0 was not aliased
    cyc(1'b0, 1'b1, 1'b1, 30'h400, 32'hAAAA_5555);
    cyc(1'b0, 1'b1, 1'b0, 30'h401, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 30'h7FF, 32'h0BAD_0BAD);
    cyc(1'b0, 1'b1, 1'b0, 30'h0, 32'h0);
    idle(LAT + 1);

    // reset while two reads are in flight
    cyc(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 30'd0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 30'd1, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    idle(LAT + 2);

    // fill a working window, then random traffic
    for (int i = 0; i < 32; i++) cyc(1'b0, 1'b1, 1'b1, 30'(i), $urandom);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 30'($urandom_range(0, 31)), $urandom);
      end else if (r < 30) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 9) == 0) a = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom)};
        else a = 30'($urandom_range(0, 31));
        cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    idle(LAT + 1);

    // counter saturation
    cyc(1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1, 30'd9, 32'(i));
    idle(LAT + 3);

    fin_req = 1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge CLK);
    if (!fin_done) begin
      $display("FAIL drain_timeout fin_done=%0d want=1", fin_done);
      $fatal(1, "monitor did not complete");
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toy_dmem_responder.md
# toy_dmem_responder

Data-memory responder for the RISC_TOY core: the slave end of the core's DREQ/DRW/DADDR/DWDATA/DRDATA data port. It holds a word-addressed memory array and services one request per cycle with a fixed, parameterised read latency. It flags out-of-range accesses and counts traffic. The testbench and FPGA top instantiate it directly opposite the core.

## Interface
- AW, default 10: log2 of memory depth in 32-bit words (1024 words).
- BASE, default 30'h0: word address of entry 0; must be aligned to 2^AW.
- LAT, default 1: read latency in cycles, legal range 1..4.
- CW, default 16: width of the access counters.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; synchronous and active-high, sampled on the CLK rising edge.
- DREQ  in  1  request valid; sampled every cycle.
- DRW  in  1  1 = write, 0 = read.
- DADDR  in  30  word address.
- DWDATA  in  32  write data.
- DRDATA  out  32  read data; holds the last returned value.
- RVALID  out  1  one-cycle pulse marking a new DRDATA value.
- RD_CNT  out  CW  accepted reads; saturating.
- WR_CNT  out  CW  accepted writes; saturating.
- ERR  out  1  sticky out-of-range flag.
- ERR_ADDR  out  30  DADDR of the first out-of-range access.

## Operation
- No back-pressure. Every cycle with DREQ=1 is an accepted request, and the core may issue back-to-back requests.
- In-range test: DADDR[29:AW] == BASE[29:AW]. Array index = DADDR[AW-1:0].
- Write (DREQ=1, DRW=1, in range):
  - mem[index] <= DWDATA at the sampling edge.
  - WR_CNT increments.
- Read (DREQ=1, DRW=0, in range):
  - mem[index] enters a LAT-deep pipeline of {valid, data}.
  - RD_CNT increments.
- Out-of-range write: dropped and not counted. Sets ERR.
- Out-of-range read: returns 32'h0 with a normal RVALID at normal latency. It is counted in RD_CNT and sets ERR.
- ERR_ADDR is loaded only when ERR is 0; later errors do not overwrite it.
- Counters stop at all-ones; no wrap.
- Read-after-write to the same address on the next cycle returns the new data, because the write commits before the read samples the array.
- DREQ=0 cycles push a bubble (valid=0) into the pipeline. DRDATA keeps its last value.
- Reset clears:
  - the pipeline valid bits;
  - DRDATA to 0, RVALID to 0;
  - RD_CNT and WR_CNT to 0;
  - ERR to 0, ERR_ADDR to 0.
- Memory contents are not reset; initial contents are undefined unless preloaded by the bench via hierarchical $readmemh.

## Timing
- Read accepted at edge n → DRDATA updated and RVALID=1 at edge n+LAT-1.
  - LAT=1: data visible in the cycle directly after the request, matching the core's MEM-stage capture.
- Fully pipelined: N consecutive reads produce N consecutive RVALID pulses, in order, with no gaps.
- Write: takes effect at edge n. No response; RVALID stays 0 for that slot.
- Counters and ERR update at the accepting edge n, independent of LAT.
- RST=1 at edge n:
  - all in-flight reads are discarded;
  - any request presented in that cycle is ignored: no write commit, no count, no ERR;
  - the first request accepted after release is the one at the first edge with RST=0.
- Outputs are registered. There is no combinational path from DREQ/DADDR to DRDATA/RVALID.

## Test plan
- Write/readback, LAT=1:
  - Stimulus: write 32'hDEADBEEF to word 5, then read word 5 on the next cycle.
  - Required: DRDATA=32'hDEADBEEF with RVALID=1 one cycle after the read; WR_CNT=1, RD_CNT=1.
- Pipelined reads, LAT=3:
  - Stimulus: preload words 0..3 with 0x10..0x13, then issue 4 back-to-back reads of words 0..3.
  - Required: RVALID high for 4 consecutive cycles starting 2 cycles after the first read, data 0x10, 0x11, 0x12, 0x13 in order.
- Out of range, BASE=0, AW=10:
  - Stimulus: write to 30'h400, then read 30'h401.
  - Required: write dropped, read returns 0 with RVALID, ERR=1, ERR_ADDR=30'h400, WR_CNT=0, RD_CNT=1.
- Reset mid-flight, LAT=4:
  - Stimulus: issue 2 reads, then RST=1 for one cycle two edges later.
  - Required: no RVALID pulse from either read; DRDATA=0; counters=0.
- Hold and bubbles:
  - Stimulus: read word 7 (value 0x77), then idle 5 cycles.
  - Required: exactly one RVALID pulse; DRDATA stays 0x77 throughout.
- Counter saturation, CW=4:
  - Stimulus: issue 20 writes.
  - Required: WR_CNT=4'hF and holds there.
